// File: rtl/lynx_kbd_pkg.sv
// Shared types, scancode constants and the set-2 to Lynx matrix key map
// for the Lynx PS/2 keyboard front end.
package lynx_kbd_pkg;

  localparam int ROWS_DEFAULT = 10;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_BAT_FAIL = 8'hFC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // "bit" is reserved in SystemVerilog, so the column field is col_bit.
  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col_bit;
  } key_pos_t;

  function automatic key_pos_t key_at(input logic [3:0] r, input logic [2:0] b);
    key_pos_t kp;
    kp.hit     = 1'b1;
    kp.row     = r;
    kp.col_bit = b;
    return kp;
  endfunction

  function automatic key_pos_t scancode_map(input logic ext, input logic [7:0] code);
    key_pos_t kp;
    kp = '0;
    case ({ext, code})
      9'h012, 9'h059: kp = key_at(4'd0, 3'd0);  // both shifts share one bit
      9'h076:         kp = key_at(4'd0, 3'd1);
      9'h016:         kp = key_at(4'd1, 3'd0);
      9'h01E:         kp = key_at(4'd1, 3'd1);
      9'h015:         kp = key_at(4'd2, 3'd0);
      9'h01C:         kp = key_at(4'd2, 3'd1);
      9'h01A:         kp = key_at(4'd2, 3'd2);
      9'h029:         kp = key_at(4'd7, 3'd0);
      9'h16B:         kp = key_at(4'd8, 3'd0);
      9'h172:         kp = key_at(4'd8, 3'd1);
      9'h175:         kp = key_at(4'd8, 3'd2);
      9'h174:         kp = key_at(4'd8, 3'd3);
      9'h05A, 9'h15A: kp = key_at(4'd9, 3'd3);
      default:        kp = '0;
    endcase
    return kp;
  endfunction

endpackage

// File: rtl/lynx_ps2_keyboard_ps2_rx.sv
// PS/2 frame receiver: input synchronizers, start/data/parity/stop FSM and
// inactivity timeout. Emits single-cycle byte-valid and error strobes.
module ps2_rx
  import lynx_kbd_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]  clk_s_q, data_s_q;
  logic        clk_prev_q;
  ps2_state_t  state_q, state_d;
  logic [2:0]  bits_q, bits_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic        fall;

  // Synchronizers start high so a released bus never looks like an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s_q    <= 2'b11;
      data_s_q   <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bits_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      clk_s_q    <= {clk_s_q[0], ps2_clk};
      data_s_q   <= {data_s_q[0], ps2_data};
      clk_prev_q <= clk_s_q[1];
      state_q    <= state_d;
      bits_q     <= bits_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
    end
  end

  assign fall   = clk_prev_q & ~clk_s_q[1];
  assign byte_o = shift_q;

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    par_d   = par_q;
    tmo_d   = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;
    valid_o = 1'b0;
    err_o   = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_s_q[1]) begin
            state_d = DATA;
            bits_d  = '0;
          end
        end
        DATA: begin
          shift_d = {data_s_q[1], shift_q[7:1]};
          bits_d  = bits_q + 1'b1;
          if (bits_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s_q[1];
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if ((^{shift_q, par_q}) && data_s_q[1]) valid_o = 1'b1;
          else                                     err_o   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == CW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      tmo_d   = '0;
      err_o   = 1'b1;
    end
  end

endmodule

// File: rtl/lynx_ps2_keyboard.sv
// Lynx keyboard front end: E0/F0 prefix tracking, key matrix maintenance and
// active-low CPU row reads on top of the PS/2 receiver.
module lynx_ps2_keyboard
  import lynx_kbd_pkg::*;
#(
  parameter int TIMEOUT = 50000,
  parameter int ROWS    = ROWS_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] row_i,
  output logic [7:0] col_o,
  output logic [7:0] code_o,
  output logic       code_stb_o,
  output logic       err_o
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_o   (rx_byte),
    .valid_o  (rx_valid),
    .err_o    (rx_err)
  );

  logic [ROWS-1:0][7:0] matrix_q, matrix_d;
  logic [7:0] code_q, code_d;
  logic       stb_q, stb_d;
  logic       err_q, err_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  key_pos_t   kp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      matrix_q <= '0;
      code_q   <= '0;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      matrix_q <= matrix_d;
      code_q   <= code_d;
      stb_q    <= stb_d;
      err_q    <= err_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
    end
  end

  always_comb begin
    matrix_d = matrix_q;
    code_d   = code_q;
    stb_d    = rx_valid;
    err_d    = rx_err;
    ext_d    = ext_q;
    brk_d    = brk_q;
    kp       = scancode_map(ext_q, rx_byte);
    if (rx_valid) begin
      code_d = rx_byte;
      case (rx_byte)
        SC_EXT: ext_d = 1'b1;
        SC_BRK: brk_d = 1'b1;
        SC_BAT_OK, SC_BAT_FAIL: begin
          matrix_d = '0;
          ext_d    = 1'b0;
          brk_d    = 1'b0;
        end
        default: begin
          // Shared bits simply take the most recent make/break.
          if (kp.hit && int'(kp.row) < ROWS) matrix_d[kp.row][kp.col_bit] = ~brk_q;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  assign col_o      = (int'(row_i) < ROWS) ? ~matrix_q[row_i] : 8'hFF;
  assign code_o     = code_q;
  assign code_stb_o = stb_q;
  assign err_o      = err_q;

endmodule

// File: doc/lynx_ps2_keyboard.md
# lynx_ps2_keyboard

PS/2 keyboard front end for the Lynx 48/96 core. It receives the two-wire PS/2 stream that the HPS I/O block emits (`ps2[0]` clock, `ps2[1]` data) and decodes set-2 make/break codes, including E0/F0 prefixes. It maintains the 10-row by 8-column Lynx key matrix and answers CPU row reads with active-low column data. It sits directly upstream of the `lynx48` machine core and replaces ad-hoc decoding inside it.

## Interface
Parameters:
- `TIMEOUT`, 50000: clock cycles without a PS/2 clock falling edge before a partial frame is abandoned.
- `ROWS`, 10: number of matrix rows.

Ports:
- `clock`  in  1  system clock (`clk_sys`).
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `ps2_clk`  in  1  PS/2 clock from HPS I/O; asynchronous to `clock`.
- `ps2_data`  in  1  PS/2 data from HPS I/O; asynchronous to `clock`.
- `row_i`  in  4  matrix row selected by the CPU (A8–A11 of port 0x80 read).
- `col_o`  out  8  active-low column bits for `row_i`.
- `code_o`  out  8  last accepted scancode byte.
- `code_stb_o`  out  1  one-cycle pulse when `code_o` updates.
- `err_o`  out  1  one-cycle pulse on parity/framing error or timeout.

## Operation
- **Input sync:** 2-flop synchronizers on both PS/2 lines. A falling edge is a synchronized clock of 1 then 0.
- **Receiver FSM states:**
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. If data=1, stay in IDLE.
  - DATA: shift data in LSB-first on each falling edge. After 8 bits go to PARITY.
  - PARITY: sample the parity bit, go to STOP.
  - STOP: sample the stop bit, then return to IDLE.
- **Frame acceptance:** a frame is good if the 8 data bits plus the parity bit have odd parity and the stop bit is 1. A good frame loads `code_o` and pulses `code_stb_o`. A bad frame pulses `err_o` and the byte is discarded.
- **Timeout:** a counter clears on every falling edge. If it reaches `TIMEOUT` in any state other than IDLE, the FSM returns to IDLE, `err_o` pulses, and the partial byte is discarded.
- **Prefix tracking:** flags `ext` and `brk`.
  - Byte E0 sets `ext`. Byte F0 sets `brk`.
  - Any other byte is a key event: it is looked up with {`ext`, byte}, and then both flags clear.
  - An F0 that arrives before an E0 keeps `brk` set when E0 arrives.
- **Map lookup:** returns {hit, row[3:0], bit[2:0]}.
  - On a hit, matrix[row][bit] is set to 1 on make and cleared to 0 on break.
  - On a miss, the matrix is unchanged.
  - Key-map examples: 0x12 (left shift) and 0x59 (right shift) → row 0 bit 0; 0x1C (A) → row 2 bit 1; 0x5A (Enter) → row 9 bit 3; E0 0x75 (up) → row 8 bit 2.
- **Shared bits:** two keys that map to the same matrix bit follow last-event-wins. Releasing either shift clears row 0 bit 0.
- **Keyboard reset codes:** bytes AA (BAT OK) and FC (BAT fail) clear the whole matrix and both prefix flags.
- **Row read:** `col_o` = ~matrix[`row_i`] when `row_i` < `ROWS`, otherwise 8'hFF. It is combinational from the matrix register and `row_i`.
- **Simultaneous events:** a matrix update and a CPU read in the same cycle return the pre-update value; the new value appears the next cycle.

## Timing
- **Reset values:** matrix all 0, `col_o` = 8'hFF for every row, `code_o` = 8'h00, `code_stb_o` = 0, `err_o` = 0, FSM = IDLE, flags clear, timeout counter 0.
- **Reset mid-frame:** the partial frame is lost; no strobe or error is produced.
- **Edge detect:** a falling edge is detected 2–3 clocks after the `ps2_clk` pin falls.
- **Accept latency:** `code_stb_o` asserts 1 clock after the stop-bit edge is detected. The matrix updates on the same clock edge that asserts `code_stb_o`.
- **Read latency:** `col_o` reflects a matrix change 1 clock after the update (zero added latency to the read).
- **Error latency:** `err_o` pulses 1 clock after the stop-bit edge for a bad frame, or in the clock where the timeout counter reaches `TIMEOUT`.

## Structure
- Package `lynx_kbd_pkg`:
  - constants `ROWS_DEFAULT`, `SC_EXT` = 8'hE0, `SC_BRK` = 8'hF0, `SC_BAT_OK` = 8'hAA, `SC_BAT_FAIL` = 8'hFC;
  - enum `ps2_state_t` {IDLE, DATA, PARITY, STOP};
  - struct `key_pos_t` {hit, row, bit};
  - function `scancode_map(ext, code)` returning `key_pos_t`.
- One sub-module, `ps2_rx`: synchronizers, receiver FSM, parity check and timeout; outputs byte/strobe/error.
- Prefix handling, matrix and row read stay in the top level.

## Test plan
- Serialize frame 0x1C with correct odd parity at a 10 kHz PS/2 clock → `code_stb_o` pulses once with `code_o` = 8'h1C; `row_i` = 2 gives `col_o` = 8'hFD.
- Send F0 1C after the previous test → row 2 reads 8'hFF; `code_stb_o` pulses twice; no `err_o`.
- Send E0 75, then E0 F0 75 → row 8 reads 8'hFB after the make and 8'hFF after the break.
- Send frame 0x1C with wrong parity → `err_o` pulses; matrix and `code_o` unchanged.
- Send 4 bits, then hold the PS/2 clock high for `TIMEOUT` cycles → `err_o` pulses. A following full frame 0x5A is accepted and row 9 reads 8'hF7.
- Press 0x12 and 0x1C, then send AA → all rows read 8'hFF. Separately, assert `reset` mid-frame → all outputs return to reset values with no pulses.
